// File: rtl/io_pinmux_wb_if.sv
// Wishbone slave bus bundle for the pad multiplexer.
interface io_pinmux_wb_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/io_pinmux_wb.sv
// Wishbone-programmable pad multiplexer: double-buffered 4-bit selects per pad,
// atomic commit with a one-cycle break-before-make on changed pads, and
// synchronised pad inputs fanned out to the selected function only.
module io_pinmux_wb #(
    parameter int NPADS       = 38,
    parameter int NFUNC       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int RESET_FUNC  = 0
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    io_pinmux_wb_if.slave          wb,
    input  logic [NPADS*NFUNC-1:0] fn_out_i,
    input  logic [NPADS*NFUNC-1:0] fn_oeb_i,
    output logic [NPADS*NFUNC-1:0] fn_in_o,
    input  logic [NPADS-1:0]       io_in,
    output logic [NPADS-1:0]       io_out,
    output logic [NPADS-1:0]       io_oeb
);
    localparam logic [3:0] RST_SEL  = 4'(RESET_FUNC);
    localparam logic [5:0] IDX_CTRL = 6'h10;
    localparam logic [5:0] IDX_STAT = 6'h11;

    typedef enum logic {IDLE, BRK} state_t;

    logic [NPADS-1:0][3:0] shadow_q, shadow_d, active_q, active_d, snap_q, snap_d;
    logic                  lock_q, lock_d;
    state_t                state_q, state_d;
    logic                  ack_q;
    logic [31:0]           dat_q, dat_d, rdata;
    logic                  accept, wr, commit, pending;
    logic [5:0]            idx;
    logic [SYNC_STAGES-1:0][NPADS-1:0] sync_q;
    logic                  unused_adr;

    assign accept     = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
    assign wr         = accept & wb.wbs_we_i;
    assign idx        = wb.wbs_adr_i[7:2];
    assign unused_adr = ^{wb.wbs_adr_i[31:8], wb.wbs_adr_i[1:0]};

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;

    // Any pad whose shadow select differs from the live one is awaiting commit.
    always_comb begin
        pending = 1'b0;
        for (int p = 0; p < NPADS; p++)
            if (shadow_q[p] != active_q[p]) pending = 1'b1;
    end

    // Register read mux; select words reflect the shadow copy.
    always_comb begin
        rdata = '0;
        if (idx == IDX_CTRL)
            rdata = {30'd0, lock_q, 1'b0};
        else if (idx == IDX_STAT)
            rdata = {30'd0, state_q == BRK, pending};
        else
            for (int p = 0; p < NPADS; p++)
                if (int'(idx) == p / 8) rdata[4*(p%8) +: 4] = shadow_q[p];
    end

    // Shadow writes, CTRL decode and the IDLE/BREAK commit sequencer.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        snap_d   = snap_q;
        lock_d   = lock_q;
        state_d  = state_q;
        commit   = 1'b0;
        dat_d    = (accept && !wb.wbs_we_i) ? rdata : 32'd0;
        if (wr && !lock_q)
            for (int p = 0; p < NPADS; p++)
                if (int'(idx) == p / 8 && wb.wbs_sel_i[(p%8)/2])
                    shadow_d[p] = wb.wbs_dat_i[4*(p%8) +: 4];
        if (wr && idx == IDX_CTRL && wb.wbs_sel_i[0]) begin
            // Commit is judged against the old LOCK so COMMIT|LOCK commits first.
            commit = wb.wbs_dat_i[0] & ~lock_q;
            lock_d = lock_q | wb.wbs_dat_i[1];
        end
        case (state_q)
            IDLE: if (commit) begin
                snap_d  = shadow_q;
                state_d = BRK;
            end
            BRK: begin
                active_d = snap_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and bus state registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            shadow_q <= {NPADS{RST_SEL}};
            active_q <= {NPADS{RST_SEL}};
            snap_q   <= {NPADS{RST_SEL}};
            lock_q   <= 1'b0;
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            snap_q   <= snap_d;
            lock_q   <= lock_d;
            state_q  <= state_d;
            ack_q    <= accept;
            dat_q    <= dat_d;
        end
    end

    // Pad input synchronisers, idle-high.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) sync_q <= '1;
        else if (SYNC_STAGES > 1) sync_q <= {sync_q[SYNC_STAGES-2:0], io_in};
        else sync_q <= io_in;
    end

    for (genvar p = 0; p < NPADS; p++) begin : g_pad
        logic [3:0]  a;
        logic        brk_hold, o, e;
        logic [15:0] fo, fe;

        assign a        = active_q[p];
        assign brk_hold = (state_q == BRK) && (snap_q[p] != active_q[p]);

        // Pad output mux; tristate while breaking or on an out-of-range select.
        always_comb begin
            fo = '0;
            fe = '1;
            fo[NFUNC-1:0] = fn_out_i[p*NFUNC +: NFUNC];
            fe[NFUNC-1:0] = fn_oeb_i[p*NFUNC +: NFUNC];
            o = 1'b0;
            e = 1'b1;
            if (!brk_hold && int'(a) < NFUNC) begin
                o = fo[a];
                e = fe[a];
            end
        end

        assign io_out[p] = o;
        assign io_oeb[p] = e;

        for (genvar f = 0; f < NFUNC; f++) begin : g_fn
            assign fn_in_o[p*NFUNC+f] = (int'(a) == f) ? sync_q[SYNC_STAGES-1][p] : 1'b1;
        end
    end
endmodule

// File: tb/tb_io_pinmux_wb.sv
// Bench for io_pinmux_wb: register table, commit/break sequences, input sync,
// lock and reset-abort cases, and randomized write/commit rounds against a model.
module tb_io_pinmux_wb;
    localparam int NP = 38;
    localparam int NF = 4;
    localparam int NW = (NP + 7) / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_pinmux_wb_if wb ();
    logic [NP*NF-1:0] fn_out, fn_oeb, fn_in;
    logic [NP-1:0]    io_in, io_out, io_oeb;

    io_pinmux_wb #(.NPADS(NP), .NFUNC(NF), .SYNC_STAGES(2), .RESET_FUNC(0)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (wb),
        .fn_out_i (fn_out),
        .fn_oeb_i (fn_oeb),
        .fn_in_o  (fn_in),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    int nvec = 0;
    int nmis = 0;

    // Model: selects as plain integers per pad.
    int sh[NP], act[NP], snap[NP];
    bit lock, pend;

    typedef struct {
        bit          we;
        logic [7:0]  a;
        logic [3:0]  sel;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [159:0] got, input logic [159:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int p = 0; p < NP; p++) begin sh[p] = 0; act[p] = 0; snap[p] = 0; end
        lock = 0;
        pend = 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        logic [31:0] r = 0;
        if (a == 8'h40) r = {30'd0, lock, 1'b0};
        else if (a == 8'h44) begin
            for (int p = 0; p < NP; p++) if (sh[p] != act[p]) r[0] = 1'b1;
        end else if (a[1:0] == 0 && int'(a) < 4 * NW) begin
            for (int i = 0; i < 8; i++)
                if (8 * (a / 4) + i < NP) r[4*i +: 4] = 4'(sh[8*(a/4)+i]);
        end
        return r;
    endfunction

    function automatic void m_write(input logic [7:0] a, input logic [3:0] sel, input logic [31:0] d);
        if (int'(a) < 4 * NW && !lock) begin
            for (int i = 0; i < 8; i++)
                if (8 * (a / 4) + i < NP && sel[i/2]) sh[8*(a/4)+i] = int'(d[4*i +: 4]);
        end
        if (a == 8'h40 && sel[0]) begin
            if (d[0] && !lock) begin
                for (int p = 0; p < NP; p++) snap[p] = sh[p];
                pend = 1;
            end
            if (d[1]) lock = 1;
        end
    endfunction

    function automatic logic [NP-1:0] m_out(input bit brk);
        logic [NP-1:0] r = '0;
        for (int p = 0; p < NP; p++)
            if (!(brk && snap[p] != act[p]) && act[p] < NF) r[p] = fn_out[p*NF+act[p]];
        return r;
    endfunction

    function automatic logic [NP-1:0] m_oeb(input bit brk);
        logic [NP-1:0] r = '1;
        for (int p = 0; p < NP; p++)
            if (!(brk && snap[p] != act[p]) && act[p] < NF) r[p] = fn_oeb[p*NF+act[p]];
        return r;
    endfunction

    function automatic logic [NP*NF-1:0] m_fnin();
        logic [NP*NF-1:0] r = '1;
        for (int p = 0; p < NP; p++)
            if (act[p] < NF) r[p*NF+act[p]] = io_in[p];
        return r;
    endfunction

    task automatic check_pads(input string nm, input bit brk);
        check({nm, "_out"}, 160'(io_out), 160'(m_out(brk)));
        check({nm, "_oeb"}, 160'(io_oeb), 160'(m_oeb(brk)));
    endtask

    // One Wishbone transfer; returns at 1 ns after the ack-raising edge.
    task automatic wb_xfer(input bit we, input logic [7:0] a, input logic [3:0] sel,
                           input logic [31:0] d, output logic [31:0] rd);
        if (wb.wbs_ack_o) begin @(posedge clk); #1; end
        wb.wbs_stb_i = 1; wb.wbs_cyc_i = 1; wb.wbs_we_i = we;
        wb.wbs_adr_i = {24'd0, a}; wb.wbs_sel_i = sel; wb.wbs_dat_i = d;
        @(posedge clk);
        if (we) m_write(a, sel, d);
        #1;
        check("ack", 160'(wb.wbs_ack_o), 160'(1));
        rd = wb.wbs_dat_o;
        wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a);
        logic [31:0] rd;
        wb_xfer(0, a, 4'hF, 32'd0, rd);
        check(nm, 160'(rd), 160'(m_read(a)));
    endtask

    task automatic do_commit(input string nm, input logic [31:0] ctrl);
        logic [31:0] rd;
        wb_xfer(1, 8'h40, 4'h1, ctrl, rd);
        check_pads({nm, "_brk"}, pend);
        @(posedge clk); #1;
        if (pend) begin
            for (int p = 0; p < NP; p++) act[p] = snap[p];
            pend = 0;
        end
        check_pads({nm, "_post"}, 0);
        check({nm, "_ackdrop"}, 160'(wb.wbs_ack_o), 160'(0));
    endtask

    task automatic rand_fn();
        for (int i = 0; i < NP * NF; i++) begin
            fn_out[i] = 1'($urandom);
            fn_oeb[i] = 1'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        logic [31:0] rd;

        tbl[0]  = '{0, 8'h00, 4'hF, 32'h0,        32'h0};
        tbl[1]  = '{0, 8'h44, 4'hF, 32'h0,        32'h0};
        tbl[2]  = '{1, 8'h00, 4'hF, 32'h00002000, 32'h0};
        tbl[3]  = '{0, 8'h44, 4'hF, 32'h0,        32'h1};
        tbl[4]  = '{0, 8'h00, 4'hF, 32'h0,        32'h00002000};
        tbl[5]  = '{1, 8'h04, 4'h2, 32'hABCDF5EF, 32'h0};
        tbl[6]  = '{0, 8'h04, 4'hF, 32'h0,        32'h0000F500};
        tbl[7]  = '{1, 8'h10, 4'hF, 32'hFFFFFFFF, 32'h0};
        tbl[8]  = '{0, 8'h10, 4'hF, 32'h0,        32'h00FFFFFF};
        tbl[9]  = '{0, 8'h80, 4'hF, 32'h0,        32'h0};
        tbl[10] = '{1, 8'h48, 4'hF, 32'hFFFFFFFF, 32'h0};
        tbl[11] = '{0, 8'h48, 4'hF, 32'h0,        32'h0};
        tbl[12] = '{0, 8'h40, 4'hF, 32'h0,        32'h0};
        tbl[13] = '{0, 8'h00, 4'hF, 32'h0,        32'h00002000};

        wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
        wb.wbs_sel_i = 0; wb.wbs_dat_i = 0; wb.wbs_adr_i = 0;
        rand_fn();
        fn_out[12] = 1'b1; fn_oeb[12] = 1'b0;
        io_in = '0;
        rst = 1;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 160'(wb.wbs_ack_o), 160'(0));
        check("rst_dat", 160'(wb.wbs_dat_o), 160'(0));
        check("rst_fnin", 160'(fn_in), 160'({NP*NF{1'b1}}));
        check("rst_oeb3", 160'(io_oeb[3]), 160'(fn_oeb[12]));
        check_pads("rst", 0);
        rst = 0;
        @(posedge clk); #1;

        // Register table.
        for (int i = 0; i < 14; i++) begin
            wb_xfer(tbl[i].we, tbl[i].a, tbl[i].sel, tbl[i].d, rd);
            if (!tbl[i].we) check($sformatf("tbl%0d", i), 160'(rd), 160'(tbl[i].exp));
        end
        check_pads("shadow_only", 0);

        // Commit: pad 3 -> func 2, pads 10/11 -> 5/F, pads 32..37 -> F.
        do_commit("c1", 32'h1);
        check("c1_pad3", 160'(io_out[3]), 160'(fn_out[14]));
        check("c1_pad11_oeb", 160'(io_oeb[11]), 160'(1));
        rd_chk("c1_stat", 8'h44);

        // Input synchroniser: pad 5 on func 1.
        wb_xfer(1, 8'h00, 4'hF, 32'h00102000, rd);
        do_commit("c2", 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("sync_base", 160'(fn_in), 160'(m_fnin()));
        io_in[5] = 1'b1;
        @(posedge clk); #1;
        check("sync_1cyc", 160'(fn_in[23:20]), 160'(4'b1101));
        @(posedge clk); #1;
        check("sync_2cyc", 160'(fn_in[23:20]), 160'(4'b1111));
        check("sync_all", 160'(fn_in), 160'(m_fnin()));

        // Randomized write/commit rounds.
        for (int it = 0; it < 40; it++) begin
            logic [7:0]  a;
            logic [3:0]  sel;
            logic [31:0] d;
            rand_fn();
            for (int p = 0; p < NP; p++) io_in[p] = 1'($urandom);
            #1;
            check_pads("rnd_pre", 0);
            a   = 8'(4 * $urandom_range(0, NW - 1));
            sel = 4'($urandom);
            d   = $urandom;
            wb_xfer(1, a, sel, d, rd);
            rd_chk("rnd_rd", a);
            rd_chk("rnd_stat", 8'h44);
            do_commit("rnd", 32'h1);
            check("rnd_fnin", 160'(fn_in), 160'(m_fnin()));
        end

        // Lock: COMMIT|LOCK commits then locks; later writes/commits ignored.
        wb_xfer(1, 8'h00, 4'hF, 32'h00000001, rd);
        do_commit("lk", 32'h3);
        rd_chk("lk_ctrl", 8'h40);
        wb_xfer(1, 8'h00, 4'hF, 32'h22222222, rd);
        rd_chk("lk_w0", 8'h00);
        do_commit("lk_ign", 32'h1);
        rd_chk("lk_ctrl2", 8'h40);

        // Reset during BREAK aborts the commit.
        rst = 1; m_reset();
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        rd_chk("rr_ctrl", 8'h40);
        wb_xfer(1, 8'h00, 4'hF, 32'h33333333, rd);
        wb_xfer(1, 8'h40, 4'h1, 32'h1, rd);
        rst = 1;
        m_reset();
        #1;
        check("rr_ack", 160'(wb.wbs_ack_o), 160'(0));
        check_pads("rr_in", 0);
        @(posedge clk); #1;
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        check_pads("rr_after", 0);
        rd_chk("rr_w0", 8'h00);
        rd_chk("rr_stat", 8'h44);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/io_pinmux_wb.md
Name: io_pinmux_wb

Overview:
- Wishbone-programmable pad multiplexer for the Caravel user area. It generalises the fixed one-function-per-pad wiring to NPADS pads, each selectable among NFUNC peripheral functions.
- Selection registers are double-buffered: software writes shadow selects, then commits them atomically.
- A commit uses break-before-make, tristating changed pads for one cycle.
- Pad inputs are synchronised before reaching peripherals.
- Sits between the SoC peripherals and io_in/io_out/io_oeb.

Parameters:
- NPADS, 38, number of pads; must be 1..64.
- NFUNC, 4, functions per pad; must be 1..16. Function 0 is GPIO by convention.
- SYNC_STAGES, 2, flops in each pad-input synchroniser; must be ≥2.
- RESET_FUNC, 0, function index loaded into every shadow and active select at reset.

Ports:
- wb_clk_i  in  1  system clock; all flops on rising edge.
- wb_rst_i  in  1  reset. Asynchronous and active-high; all state goes to reset values.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  address; only [7:2] decoded.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- fn_out_i  in  NPADS*NFUNC  output value of function f for pad p, at bit p*NFUNC+f.
- fn_oeb_i  in  NPADS*NFUNC  active-low output enable of function f for pad p.
- fn_in_o  out  NPADS*NFUNC  synchronised pad input delivered to function f of pad p.
- io_in  in  NPADS  pad inputs.
- io_out  out  NPADS  pad outputs.
- io_oeb  out  NPADS  pad active-low output enables.

Behaviour:
- Select fields are 4 bits. Word k (byte offset 4k, k=0..ceil(NPADS/8)-1) holds pads 8k..8k+7, with pad 8k+i at bits [4i+3:4i].
- 0x40 CTRL (write/read):
  - bit0 COMMIT: write 1 starts a commit; self-clearing; always reads 0.
  - bit1 LOCK: sticky; cleared only by reset.
- 0x44 STATUS (read-only):
  - bit0 PENDING: shadow != active.
  - bit1 BUSY: FSM in BREAK.
- Unmapped addresses read 0; writes to them are ignored but still acked.
- Field bits for pads ≥ NPADS read 0 and are not writable.
- Wishbone transfer:
  - A transfer is accepted when stb&cyc&!ack. wbs_ack_o is high for exactly the following cycle.
  - The write takes effect on the accept edge, honouring wbs_sel_i per byte.
  - wbs_dat_o is registered, valid while ack is high, and 0 otherwise.
  - Back-to-back transfers complete every 2 cycles.
- While LOCK=1, shadow writes and COMMIT are ignored; the transfer is still acked. Writing LOCK=1 together with COMMIT=1 performs the commit, then locks.
- FSM states IDLE and BREAK:
  - IDLE, commit accepted at edge T: snapshot <= shadow; go to BREAK.
  - BREAK (cycle T..T+1): every pad whose snapshot field differs from its active field drives io_oeb=1 and io_out=0. Unchanged pads are unaffected.
  - Leaving BREAK at edge T+1: active <= snapshot; go to IDLE.
  - Shadow writes during BREAK land in shadow only; active still loads the snapshot.
  - COMMIT written during BREAK is ignored.
- Output path is combinational from active selects:
  - io_out[p] = fn_out_i[p*NFUNC+a]
  - io_oeb[p] = fn_oeb_i[p*NFUNC+a]
  - where a = active select of pad p.
  - If a ≥ NFUNC, the pad is tristated: io_oeb=1, io_out=0.
- Input path:
  - io_in[p] passes through a SYNC_STAGES flop chain, reset value 1.
  - fn_in_o[p*NFUNC+a] carries the synchronised value. Every unselected function input is held at 1, the idle-high level for UART/I2C.
  - Latency from io_in to fn_in_o is SYNC_STAGES cycles.
- Reset values:
  - shadow = active = snapshot = RESET_FUNC; LOCK=0; FSM=IDLE.
  - wbs_ack_o=0, wbs_dat_o=0, fn_in_o all 1.
  - io_out and io_oeb follow the RESET_FUNC function's outputs.
- Reset asserted mid-commit aborts it: active returns to RESET_FUNC with no BREAK.

Test Plan:
- Reset, read word 0 and STATUS → 0x00000000 (RESET_FUNC=0) and 0x0; io_oeb[3] tracks fn_oeb_i[3*4+0].
- Write word 0 = 0x00002000 (pad 3 → func 2) → STATUS=0x1 and outputs unchanged. Write CTRL=0x1 → pad 3 io_oeb=1, io_out=0 for one cycle, then fn_out_i[14]; STATUS=0x0. Pads 0–2 never glitch.
- Write word 1 with wbs_sel_i=0b0010 and data 0x0000F500 → only pads 10–11 fields change. Commit → pad 11 (select F ≥ NFUNC) tristated permanently.
- Toggle io_in[5] with pad 5 on func 1 → fn_in_o[21] follows after exactly 2 cycles; fn_in_o[20,22,23] stay 1.
- Write CTRL=0x3, then shadow write and COMMIT → both ignored, acks still returned, active unchanged; LOCK reads 1 until wb_rst_i.
- Assert wb_rst_i during BREAK → all selects return to 0 immediately, wbs_ack_o=0, no stale apply after release.
